alu_mc: RTL and testbench

- Parametrised, registered, multi-cycle ALU. Successor to the combinational 8-bit datapath ALU.
- Adds width generalisation and a start/busy/done handshake.
- Adds iterative multi-bit shifts and an iterative unsigned multiply.
- Fixes subtract carry/borrow semantics.
- Sits between the register file and the writeback mux. The controller stalls fetch while BUSY is high.

---
 rtl/alu_mc.sv | 240 ++++++++++++++++++++++++
 tb/tb_alu_mc.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU with a start/busy/done handshake.
// Operands are latched on accept and executed on the following edge. Single-cycle ops finish
// there. Multi-bit shifts and the shift-add multiply continue in their own states.
module alu_mc #(
  parameter int unsigned W      = 8,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [3:0]   op_i,
  input  logic [W-1:0] inputa_i,
  input  logic [W-1:0] inputb_i,
  input  logic         sc_in_i,
  output logic [W-1:0] out_o,
  output logic [W-1:0] out_hi_o,
  output logic         sc_out_o,
  output logic         zero_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int unsigned CW = $clog2(W) + 1;
  localparam logic [W-1:0]  WMax = W'(W);
  localparam logic [CW-1:0] KMax = CW'(W);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpLsh  = 4'd1;
  localparam logic [3:0] OpRsh  = 4'd2;
  localparam logic [3:0] OpXor  = 4'd3;
  localparam logic [3:0] OpAnd  = 4'd4;
  localparam logic [3:0] OpSub  = 4'd5;
  localparam logic [3:0] OpLshn = 4'd6;
  localparam logic [3:0] OpRshn = 4'd7;
  localparam logic [3:0] OpMul  = 4'd8;

  typedef enum logic [1:0] {StIdle, StShift, StMul} state_e;

  state_e          state_q, state_d;
  logic            pend_q, pend_d;
  logic [3:0]      op_q;
  logic [W-1:0]    a_q, b_q;
  logic            sc_in_q;
  logic [2*W-1:0]  work_q, work_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic            right_q, right_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    out_q, out_d, hi_q, hi_d;
  logic            sc_q, sc_d, zero_q, zero_d, done_q, done_d;

  logic            accept, long_shift, is_mul, last_step;
  logic [CW-1:0]   k;

  // One shift step: returns {bit shifted out, shifted value}, zero fill.
  function automatic logic [W:0] shift1(input logic [W-1:0] v, input logic right);
    return right ? {v[0], 1'b0, v[W-1:1]} : {v[W-1], v[W-2:0], 1'b0};
  endfunction

  // One shift-add partial product: multiplier sits in the low half and drains out to the right.
  function automatic logic [2*W-1:0] mul_step(input logic [2*W-1:0] p, input logic [W-1:0] a);
    logic [W:0] s;
    s = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, a} : '0);
    return {s, p[W-1:1]};
  endfunction

  assign accept     = start_i && !busy_o;
  assign k          = (b_q >= WMax) ? KMax : CW'(b_q);
  assign long_shift = ((op_q == OpLshn) || (op_q == OpRshn)) && (k >= CW'(2));
  assign is_mul     = MUL_EN && (op_q == OpMul);
  assign last_step  = (cnt_q == CW'(1));

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state: leave IDLE only for long shifts and MUL, return on the last counted step.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pend_q && long_shift)  state_d = StShift;
        else if (pend_q && is_mul) state_d = StMul;
      end
      StShift, StMul: if (last_step) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy_o = (state_q != StIdle);
  end

  // Datapath next-state: results are only published into the output registers on completion.
  always_comb begin
    logic          fin;
    logic [W-1:0]  res_lo, res_hi;
    logic          res_sc;
    logic [W:0]    sum, sh;
    logic [2*W-1:0] pstep;
    pend_d  = pend_q;
    work_d  = work_q;
    mcand_d = mcand_q;
    right_d = right_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    hi_d    = hi_q;
    sc_d    = sc_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    fin     = 1'b0;
    res_lo  = '0;
    res_hi  = '0;
    res_sc  = 1'b0;
    sum     = '0;
    sh      = '0;
    pstep   = '0;
    unique case (state_q)
      StIdle: begin
        if (pend_q) begin
          pend_d = 1'b0;
          fin    = 1'b1;
          case (op_q)
            OpAdd: begin
              sum = {1'b0, a_q} + {1'b0, b_q} + {{W{1'b0}}, sc_in_q};
              {res_sc, res_lo} = sum;
            end
            OpSub: begin
              // SC_OUT=1 means no borrow
              sum = {1'b0, a_q} + {1'b0, ~b_q} + {{W{1'b0}}, sc_in_q};
              {res_sc, res_lo} = sum;
            end
            OpLsh: {res_sc, res_lo} = {a_q, sc_in_q};
            OpRsh: {res_lo, res_sc} = {sc_in_q, a_q};
            OpXor: res_lo = a_q ^ b_q;
            OpAnd: res_lo = a_q & b_q;
            OpLshn, OpRshn: begin
              if (k == '0) begin
                res_lo = a_q;
              end else begin
                sh = shift1(a_q, op_q[0]);
                if (k == CW'(1)) begin
                  {res_sc, res_lo} = sh;
                end else begin
                  fin     = 1'b0;
                  work_d  = {{W{1'b0}}, sh[W-1:0]};
                  right_d = op_q[0];
                  cnt_d   = k - CW'(1);
                end
              end
            end
            OpMul: begin
              if (MUL_EN) begin
                fin     = 1'b0;
                mcand_d = a_q;
                work_d  = mul_step({{W{1'b0}}, b_q}, a_q);
                cnt_d   = CW'(W - 1);
              end
            end
            default: ;
          endcase
        end
      end
      StShift: begin
        sh     = shift1(work_q[W-1:0], right_q);
        work_d = {{W{1'b0}}, sh[W-1:0]};
        cnt_d  = cnt_q - CW'(1);
        if (last_step) begin
          fin = 1'b1;
          {res_sc, res_lo} = sh;
        end
      end
      StMul: begin
        pstep  = mul_step(work_q, mcand_q);
        work_d = pstep;
        cnt_d  = cnt_q - CW'(1);
        if (last_step) begin
          fin = 1'b1;
          {res_hi, res_lo} = pstep;
        end
      end
      default: ;
    endcase
    // A new op may be latched while the previous one is being launched.
    if (accept) pend_d = 1'b1;
    if (fin) begin
      out_d  = res_lo;
      hi_d   = res_hi;
      sc_d   = res_sc;
      zero_d = ~|{res_hi, res_lo};
      done_d = 1'b1;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q  <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sc_in_q <= 1'b0;
      work_q  <= '0;
      mcand_q <= '0;
      right_q <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      hi_q    <= '0;
      sc_q    <= 1'b0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= op_i;
        a_q     <= inputa_i;
        b_q     <= inputb_i;
        sc_in_q <= sc_in_i;
      end
      pend_q  <= pend_d;
      work_q  <= work_d;
      mcand_q <= mcand_d;
      right_q <= right_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      sc_q    <= sc_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign out_o    = out_q;
  assign out_hi_o = hi_q;
  assign sc_out_o = sc_q;
  assign zero_o   = zero_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (W=8): stimulus pushes expected results, a monitor pops on DONE.
module tb_alu_mc;

  localparam int unsigned W = 8;
  localparam longint unsigned Mask = (64'd1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         sc_in = 1'b0;
  logic [W-1:0] out_o, out_hi_o;
  logic         sc_out_o, zero_o, busy_o, done_o;

  alu_mc #(.W(W), .MUL_EN(1'b1)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .op_i     (op),
    .inputa_i (a),
    .inputb_i (b),
    .sc_in_i  (sc_in),
    .out_o    (out_o),
    .out_hi_o (out_hi_o),
    .sc_out_o (sc_out_o),
    .zero_o   (zero_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] out;
    logic [W-1:0] hi;
    logic         sc;
    logic         zero;
    int           due;   // latency on push, absolute DONE cycle in the queue
    int           busy;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model from the opcode definitions, plain arithmetic.
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c);
    exp_t e;
    longint unsigned ax = x, by = y, s = 0;
    longint unsigned lo = 0, hi = 0, co = 0;
    int k, lat;
    lat = 1;
    k = (by > W) ? W : int'(by);
    case (o)
      4'd0: begin s = ax + by + c; lo = s & Mask; co = s >> W; end
      4'd1: begin lo = ((ax << 1) + c) & Mask; co = ax >> (W - 1); end
      4'd2: begin lo = (ax >> 1) + (longint'(c) << (W - 1)); co = ax & 1; end
      4'd3: lo = ax ^ by;
      4'd4: lo = ax & by;
      4'd5: begin s = ax + (Mask - by) + c; lo = s & Mask; co = s >> W; end
      4'd6: begin
        lo = (ax << k) & Mask;
        co = (k == 0) ? 0 : ((ax >> (W - k)) & 1);
        lat = (k > 1) ? k : 1;
      end
      4'd7: begin
        lo = ax >> k;
        co = (k == 0) ? 0 : ((ax >> (k - 1)) & 1);
        lat = (k > 1) ? k : 1;
      end
      4'd8: begin s = ax * by; lo = s & Mask; hi = s >> W; lat = W; end
      default: ;
    endcase
    e.out  = W'(lo);
    e.hi   = W'(hi);
    e.sc   = 1'(co);
    e.zero = (lo == 0) && (hi == 0);
    e.due  = lat;
    e.busy = lat - 1;
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] o, input logic [W-1:0] h, input logic s,
                              input logic z, input int lat);
    exp_t e;
    e.out = o; e.hi = h; e.sc = s; e.zero = z; e.due = lat; e.busy = lat - 1;
    return e;
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    logic [W-1:0] l_out, l_hi;
    logic         l_sc, l_zero;
    int           busy_cnt;
    exp_t         e;
    l_out = '0; l_hi = '0; l_sc = 1'b0; l_zero = 1'b1; busy_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        l_out = '0; l_hi = '0; l_sc = 1'b0; l_zero = 1'b1; busy_cnt = 0;
      end else begin
        if (busy_o) busy_cnt++;
        if (done_o) begin
          if (sbq.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("out", out_o, e.out);
            chk("out_hi", out_hi_o, e.hi);
            chk("sc_out", sc_out_o, e.sc);
            chk("zero", zero_o, e.zero);
            chk("latency_cycle", cyc, e.due);
            chk("busy_cycles", busy_cnt, e.busy);
          end
          l_out = out_o; l_hi = out_hi_o; l_sc = sc_out_o; l_zero = zero_o;
          busy_cnt = 0;
        end else begin
          chk("hold", {out_o, out_hi_o, sc_out_o, zero_o}, {l_out, l_hi, l_sc, l_zero});
        end
      end
    end
  end

  // Drive at posedge+2, accept on the next edge, then scramble inputs to prove capture.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input exp_t e);
    op = o; a = x; b = y; sc_in = c; start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    op = 4'($urandom); a = W'($urandom); b = W'($urandom); sc_in = 1'($urandom);
    e.due = cyc + e.due;
    sbq.push_back(e);
  endtask

  // Returns at posedge+2 of the DONE cycle, so the next issue is back-to-back.
  task automatic wait_idle();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (sbq.size() != 0) begin
      chk("done_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [3:0]   o;
    logic [W-1:0] x, y;
    logic         c;
    int           gap;

    #1 rst = 1'b1;
    #1;
    chk("reset_out", out_o, 0);
    chk("reset_out_hi", out_hi_o, 0);
    chk("reset_sc_out", sc_out_o, 0);
    chk("reset_zero", zero_o, 1);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #2;

    issue(4'd0, 8'hFF, 8'h01, 1'b0, mk(8'h00, 8'h00, 1'b1, 1'b1, 1));  wait_idle();
    issue(4'd5, 8'h05, 8'h07, 1'b1, mk(8'hFE, 8'h00, 1'b0, 1'b0, 1));  wait_idle();
    issue(4'd5, 8'h07, 8'h05, 1'b1, mk(8'h02, 8'h00, 1'b1, 1'b0, 1));  wait_idle();
    issue(4'd2, 8'hB3, 8'h00, 1'b1, mk(8'hD9, 8'h00, 1'b1, 1'b0, 1));  wait_idle();
    issue(4'd1, 8'hB3, 8'h00, 1'b1, mk(8'h67, 8'h00, 1'b1, 1'b0, 1));  wait_idle();
    issue(4'd6, 8'hB3, 8'd3,  1'b0, mk(8'h98, 8'h00, 1'b1, 1'b0, 3));  wait_idle();
    issue(4'd6, 8'hB3, 8'd9,  1'b0, mk(8'h00, 8'h00, 1'b1, 1'b1, 8));  wait_idle();
    issue(4'd7, 8'hB3, 8'd3,  1'b1, mk(8'h16, 8'h00, 1'b0, 1'b0, 3));  wait_idle();
    issue(4'd7, 8'hB3, 8'd8,  1'b0, mk(8'h00, 8'h00, 1'b1, 1'b1, 8));  wait_idle();
    issue(4'd6, 8'hB3, 8'd0,  1'b1, mk(8'hB3, 8'h00, 1'b0, 1'b0, 1));  wait_idle();
    issue(4'd7, 8'hB3, 8'd1,  1'b0, mk(8'h59, 8'h00, 1'b1, 1'b0, 1));  wait_idle();
    issue(4'd12, 8'hB3, 8'h11, 1'b1, mk(8'h00, 8'h00, 1'b0, 1'b1, 1)); wait_idle();

    // MUL with a START pulse while busy, which must be ignored.
    issue(4'd8, 8'hFF, 8'hFF, 1'b0, mk(8'h01, 8'hFE, 1'b0, 1'b0, 8));
    repeat (3) @(posedge clk);
    #2;
    op = 4'd3; a = 8'h55; b = 8'h0F; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    wait_idle();
    issue(4'd8, 8'h00, 8'h37, 1'b0, mk(8'h00, 8'h00, 1'b0, 1'b1, 8));  wait_idle();
    issue(4'd3, 8'hF0, 8'h0F, 1'b0, mk(8'hFF, 8'h00, 1'b0, 1'b0, 1));  wait_idle();

    // Reset in the middle of a MUL: immediate clear, no DONE.
    issue(4'd8, 8'h12, 8'h34, 1'b0, mk(8'h a8, 8'h03, 1'b0, 1'b0, 8));
    repeat (3) @(posedge clk);
    #5 rst = 1'b1;
    #1;
    chk("midreset_out", out_o, 0);
    chk("midreset_out_hi", out_hi_o, 0);
    chk("midreset_zero", zero_o, 1);
    chk("midreset_busy", busy_o, 0);
    chk("midreset_done", done_o, 0);
    sbq.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    issue(4'd0, 8'h10, 8'h20, 1'b0, mk(8'h30, 8'h00, 1'b0, 1'b0, 1));  wait_idle();

    for (int i = 0; i < 150; i++) begin
      o = 4'($urandom_range(0, 15));
      x = W'($urandom);
      y = W'($urandom);
      c = 1'($urandom_range(0, 1));
      if (o == 4'd6 || o == 4'd7) y = W'($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0) x = '0;
      issue(o, x, y, c, model(o, x, y, c));
      wait_idle();
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #2;
      end
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
